// File: rtl/legv8_fetch_unit_pkg.sv
// Shared definitions for the LEGv8 instruction-fetch stage.
//   fetchState_e : fetch FSM state encoding (also driven out for debug)
//   FLT_*        : fault codes reported on oFaultCode
//   OPC_MSB/LSB  : position of the 11-bit opcode field in an instruction
//   INSTR_BYTES  : sequential PC increment
package legv8_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_REQ   = 2'd1,
    FS_HOLD  = 2'd2,
    FS_FAULT = 2'd3
  } fetchState_e;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_TIMEOUT = 2'b01;
  localparam logic [1:0] FLT_ALIGN   = 2'b10;

  localparam int OPC_MSB     = 31;
  localparam int OPC_LSB     = 21;
  localparam int INSTR_BYTES = 4;

  // Instructions are word-aligned; any set bit in [1:0] is a bad target.
  function automatic logic isAligned(input logic [63:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/legv8_next_pc.sv
// Next-PC logic for the fetch stage (purely combinational).
//   iPC           : PC of the instruction being retired
//   iBranchTaken  : select iBranchTarget instead of iPC + 4
//   iBranchTarget : redirect address
//   oNextPC       : selected next PC (the +4 path wraps modulo 2^64)
//   oMisaligned   : oNextPC is not word-aligned
module legv8_next_pc
  import legv8_fetch_unit_pkg::*;
(
  input  logic [63:0] iPC,
  input  logic        iBranchTaken,
  input  logic [63:0] iBranchTarget,
  output logic [63:0] oNextPC,
  output logic        oMisaligned
);

  logic [63:0] seqPC;

  assign seqPC       = iPC + 64'(INSTR_BYTES);
  assign oNextPC     = iBranchTaken ? iBranchTarget : seqPC;
  assign oMisaligned = ~isAligned(oNextPC);

endmodule

// File: rtl/legv8_fetch_unit.sv
// LEGv8 instruction-fetch stage. Holds the PC, fetches from instruction
// memory, and presents the instruction to control/datapath until retired.
//   iCLK, iRST          : clock, synchronous active-high reset
//   oIMemReq, oIMemAddr : request to instruction memory (address = oPC)
//   iIMemAck, iIMemData : memory response; data is taken on ack in FS_REQ
//   iRetire             : datapath is done with the presented instruction
//   iBranchTaken/Target : redirect, only looked at on a retire in FS_HOLD
//   oPC/oInstr/oOpcode  : presented instruction, qualified by oValid
//   oFault, oFaultCode  : sticky trap (01 bus timeout, 10 misaligned target)
//   oRetired            : retired-instruction counter, wraps
//   oState              : current FSM state for debug
//
// Handshakes: oIMemReq is held high with a constant oIMemAddr until the
// cycle iIMemAck=1 is seen; that cycle completes the transfer. On the
// datapath side oValid stays high with stable outputs until a cycle with
// iRetire=1, which consumes the instruction.
module legv8_fetch_unit
  import legv8_fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 32
) (
  input  logic             iCLK,
  input  logic             iRST,
  output logic             oIMemReq,
  output logic [63:0]      oIMemAddr,
  input  logic             iIMemAck,
  input  logic [31:0]      iIMemData,
  input  logic             iRetire,
  input  logic             iBranchTaken,
  input  logic [63:0]      iBranchTarget,
  output logic [63:0]      oPC,
  output logic [31:0]      oInstr,
  output logic [10:0]      oOpcode,
  output logic             oValid,
  output logic             oFault,
  output logic [1:0]       oFaultCode,
  output logic [CNT_W-1:0] oRetired,
  output fetchState_e      oState
);

  localparam int                WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [63:0]       PC_INIT   = RESET_PC & ~64'h3;

  fetchState_e       state, stateNext;
  logic [63:0]       pcReg, pcNext;
  logic [31:0]       instrReg, instrNext;
  logic [1:0]        faultCode, faultCodeNext;
  logic [CNT_W-1:0]  retired, retiredNext;
  logic [WAIT_W-1:0] waitCnt, waitCntNext;

  logic [63:0] npc;
  logic        npcMisaligned;

  legv8_next_pc uNextPc (
    .iPC          (pcReg),
    .iBranchTaken (iBranchTaken),
    .iBranchTarget(iBranchTarget),
    .oNextPC      (npc),
    .oMisaligned  (npcMisaligned)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= FS_BOOT;
      pcReg     <= PC_INIT;
      instrReg  <= 32'h0;
      faultCode <= FLT_NONE;
      retired   <= '0;
      waitCnt   <= '0;
    end else begin
      state     <= stateNext;
      pcReg     <= pcNext;
      instrReg  <= instrNext;
      faultCode <= faultCodeNext;
      retired   <= retiredNext;
      waitCnt   <= waitCntNext;
    end
  end

  always_comb begin
    stateNext     = state;
    pcNext        = pcReg;
    instrNext     = instrReg;
    faultCodeNext = faultCode;
    retiredNext   = retired;
    waitCntNext   = waitCnt;

    case (state)
      FS_BOOT: stateNext = FS_REQ;

      FS_REQ: begin
        // An ack on the last allowed cycle is checked first, so it wins.
        if (iIMemAck) begin
          instrNext   = iIMemData;
          waitCntNext = '0;
          stateNext   = FS_HOLD;
        end else if (waitCnt == WAIT_LAST) begin
          faultCodeNext = FLT_TIMEOUT;
          stateNext     = FS_FAULT;
        end else begin
          waitCntNext = waitCnt + WAIT_W'(1);
        end
      end

      FS_HOLD: begin
        if (iRetire) begin
          // The bad target is still latched so the trap shows where it went.
          pcNext      = npc;
          retiredNext = retired + CNT_W'(1);
          if (npcMisaligned) begin
            faultCodeNext = FLT_ALIGN;
            stateNext     = FS_FAULT;
          end else begin
            stateNext = FS_REQ;
          end
        end
      end

      FS_FAULT: stateNext = FS_FAULT;

      default: stateNext = FS_BOOT;
    endcase
  end

  // oValid is high exactly while an instruction is held for the datapath.
  assign oIMemReq   = (state == FS_REQ);
  assign oIMemAddr  = pcReg;
  assign oPC        = pcReg;
  assign oInstr     = instrReg;
  assign oOpcode    = instrReg[OPC_MSB:OPC_LSB];
  assign oValid     = (state == FS_HOLD);
  assign oFault     = (state == FS_FAULT);
  assign oFaultCode = faultCode;
  assign oRetired   = retired;
  assign oState     = state;

endmodule

// File: tb/tb_legv8_fetch_unit.sv
module tb_legv8_fetch_unit;
  import legv8_fetch_unit_pkg::*;

  localparam int CNT_W = 32;
  localparam int W     = 64 + 32 + 11;

  logic             iCLK = 1'b0;
  logic             iRST = 1'b1;
  logic             oIMemReq;
  logic [63:0]      oIMemAddr;
  logic             iIMemAck = 1'b0;
  logic [31:0]      iIMemData = 32'h0;
  logic             iRetire = 1'b0;
  logic             iBranchTaken = 1'b0;
  logic [63:0]      iBranchTarget = 64'h0;
  logic [63:0]      oPC;
  logic [31:0]      oInstr;
  logic [10:0]      oOpcode;
  logic             oValid;
  logic             oFault;
  logic [1:0]       oFaultCode;
  logic [CNT_W-1:0] oRetired;
  fetchState_e      oState;

  legv8_fetch_unit #(.RESET_PC(64'h0), .TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .oIMemReq(oIMemReq), .oIMemAddr(oIMemAddr),
    .iIMemAck(iIMemAck), .iIMemData(iIMemData),
    .iRetire(iRetire), .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
    .oPC(oPC), .oInstr(oInstr), .oOpcode(oOpcode), .oValid(oValid),
    .oFault(oFault), .oFaultCode(oFaultCode), .oRetired(oRetired), .oState(oState)
  );

  // ---------------- clock / watchdog ----------------
  always #5 iCLK = ~iCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int expRetired = 0;

  logic [W-1:0] exp_q[$];   // {pc, instr, opcode} per expected presentation
  logic [65:0]  flt_q[$];   // {faultCode, pc} per expected trap

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic prevValid = 1'b0;
  logic prevFault = 1'b0;

  always @(negedge iCLK) begin
    logic [W-1:0] e;
    logic [65:0]  f;
    if (oValid && !prevValid) begin
      if (exp_q.size() == 0) chk("valid_unexpected", 64'(oValid), 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("mon_pc", oPC, e[W-1 -: 64]);
        chk("mon_instr", 64'(oInstr), 64'(e[42:11]));
        chk("mon_opcode", 64'(oOpcode), 64'(e[10:0]));
      end
    end
    if (oFault && !prevFault) begin
      if (flt_q.size() == 0) chk("fault_unexpected", 64'(oFault), 64'd0);
      else begin
        f = flt_q.pop_front();
        chk("mon_fault_code", 64'(oFaultCode), 64'(f[65:64]));
        chk("mon_fault_pc", oPC, f[63:0]);
      end
    end
    prevValid = oValid;
    prevFault = oFault;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    iRST = 1'b1; iIMemAck = 1'b0; iRetire = 1'b0;
    @(negedge iCLK); @(negedge iCLK);
    chk("rst_req", 64'(oIMemReq), 64'd0);
    chk("rst_pc", oPC, 64'h0);
    chk("rst_instr", 64'(oInstr), 64'd0);
    chk("rst_valid", 64'(oValid), 64'd0);
    chk("rst_fault", 64'(oFault), 64'd0);
    chk("rst_code", 64'(oFaultCode), 64'd0);
    chk("rst_retired", 64'(oRetired), 64'd0);
    chk("rst_state", 64'(oState), 64'(FS_BOOT));
    iRST = 1'b0;
    expRetired = 0;
    @(negedge iCLK);
  endtask

  // Wait for the request, stall dly cycles, then ack with data.
  task automatic fetch(input int dly, input logic [31:0] data, input logic [10:0] opc,
                       input logic [63:0] expPc, output int lat);
    lat = 0;
    while (!oIMemReq && lat < 40) begin @(negedge iCLK); lat++; end
    chk("req_seen", 64'(oIMemReq), 64'd1);
    chk("req_addr", oIMemAddr, expPc);
    for (int i = 0; i < dly; i++) begin
      @(negedge iCLK);
      chk("req_hold", 64'(oIMemReq), 64'd1);
      chk("addr_stable", oIMemAddr, expPc);
    end
    iIMemAck = 1'b1;
    iIMemData = data;
    exp_q.push_back({expPc, data, opc});
    @(negedge iCLK);
    iIMemAck = 1'b0;
    iIMemData = $urandom;
    chk("valid_after_ack", 64'(oValid), 64'd1);
    chk("no_fault", 64'(oFault), 64'd0);
  endtask

  task automatic retire(input logic taken, input logic [63:0] tgt);
    int n = 0;
    while (!oValid && n < 40) begin @(negedge iCLK); n++; end
    chk("valid_before_retire", 64'(oValid), 64'd1);
    iRetire = 1'b1; iBranchTaken = taken; iBranchTarget = tgt;
    @(negedge iCLK);
    iRetire = 1'b0; iBranchTaken = 1'($urandom); iBranchTarget = {$urandom, $urandom};
    expRetired++;
    chk("retired_cnt", 64'(oRetired), 64'(expRetired));
    chk("valid_after_retire", 64'(oValid), 64'd0);
  endtask

  // ---------------- directed program ----------------
  logic [63:0] vAddr [9] = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h10, 64'h14, 64'h100,
                             64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
  logic [31:0] vInstr[9] = '{32'h8B020020, 32'hF84003E1, 32'hCB020020, 32'hAA020020,
                             32'h8A020020, 32'hB4000040, 32'h14000002, 32'h8B020020,
                             32'hCB020020};
  logic [10:0] vOpc  [9] = '{11'h458, 11'h7C2, 11'h658, 11'h550, 11'h450, 11'h5A0,
                             11'h0A0, 11'h458, 11'h658};
  int          vDly  [9] = '{0, 3, 1, 0, 2, 0, 0, 0, 0};
  logic        vTaken[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [63:0] vTgt  [9] = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h100,
                             64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h102};

  initial begin
    int lat;

    // Straight-line program: sequential, branch, wrap, then misaligned branch.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      fetch(vDly[i], vInstr[i], vOpc[i], vAddr[i], lat);
      chk("req_latency", 64'(lat), 64'd0);
      if (vTgt[i][1:0] != 2'b00) flt_q.push_back({FLT_ALIGN, vTgt[i]});
      retire(vTaken[i], vTgt[i]);
    end

    // Trap is sticky: retire pulses and stray acks change nothing.
    for (int i = 0; i < 20; i++) begin
      iRetire = 1'(i % 2);
      iIMemAck = 1'($urandom_range(0, 1));
      chk("flt_req", 64'(oIMemReq), 64'd0);
      chk("flt_valid", 64'(oValid), 64'd0);
      chk("flt_sticky", 64'(oFault), 64'd1);
      chk("flt_code", 64'(oFaultCode), 64'(FLT_ALIGN));
      chk("flt_pc", oPC, 64'h102);
      @(negedge iCLK);
    end
    iRetire = 1'b0; iIMemAck = 1'b0;
    chk("flt_retired_frozen", 64'(oRetired), 64'(expRetired));

    // Bus timeout: no ack for 16 request cycles.
    do_reset();
    flt_q.push_back({FLT_TIMEOUT, 64'h0});
    for (int i = 0; i < 16; i++) begin
      chk("to_req", 64'(oIMemReq), 64'd1);
      chk("to_no_fault_yet", 64'(oFault), 64'd0);
      @(negedge iCLK);
    end
    chk("to_fault", 64'(oFault), 64'd1);
    chk("to_code", 64'(oFaultCode), 64'(FLT_TIMEOUT));
    chk("to_req_off", 64'(oIMemReq), 64'd0);

    // Ack on the 16th request cycle beats the timeout.
    do_reset();
    fetch(15, 32'h8A020020, 11'h450, 64'h0, lat);
    chk("edge_latency", 64'(lat), 64'd0);
    retire(1'b0, 64'h0);

    // Reset while requesting PC 4 with an ack pending, ack held over reset.
    chk("mid_req", 64'(oIMemReq), 64'd1);
    chk("mid_addr", oIMemAddr, 64'h4);
    iRST = 1'b1; iIMemAck = 1'b1; iIMemData = 32'hDEADBEEF;
    @(negedge iCLK);
    chk("mr_pc", oPC, 64'h0);
    chk("mr_valid", 64'(oValid), 64'd0);
    chk("mr_instr", 64'(oInstr), 64'd0);
    chk("mr_req", 64'(oIMemReq), 64'd0);
    chk("mr_retired", 64'(oRetired), 64'd0);
    iRST = 1'b0;
    expRetired = 0;
    @(negedge iCLK);
    iIMemAck = 1'b0;
    chk("late_ack_valid", 64'(oValid), 64'd0);
    chk("late_ack_instr", 64'(oInstr), 64'd0);
    chk("restart_req", 64'(oIMemReq), 64'd1);
    chk("restart_addr", oIMemAddr, 64'h0);
    fetch(0, 32'hAA020020, 11'h550, 64'h0, lat);
    chk("restart_latency", 64'(lat), 64'd0);
    retire(1'b0, 64'h0);

    repeat (3) @(negedge iCLK);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("flt_q_drained", 64'(flt_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/legv8_fetch_unit.md
Name: legv8_fetch_unit

Overview:
- Instruction-fetch stage of the LEGv8 uniciclo CPU, directly upstream of the main control decoder.
- Holds the PC and issues requests to instruction memory over a req/ack handshake that tolerates wait states.
- Presents the fetched word and its 11-bit opcode field (bits 31:21) to control and datapath until the datapath retires the instruction.
- Computes the next PC (PC+4 or branch target) and traps on bus timeout or misaligned target.

Parameters:
RESET_PC, 64'h0, PC loaded by reset; bits [1:0] ignored (forced 0)
TIMEOUT, 16, max cycles in S_REQ without iIMemAck before bus fault; minimum 2
CNT_W, 32, width of retired-instruction counter

Ports:
iCLK  input  1  clock, rising edge
iRST  input  1  synchronous active-high reset
oIMemReq  output  1  fetch request to instruction memory
oIMemAddr  output  64  fetch address (= oPC)
iIMemAck  input  1  memory has valid data this cycle
iIMemData  input  32  instruction word, sampled when iIMemAck=1 in S_REQ
iRetire  input  1  datapath finished current instruction
iBranchTaken  input  1  current instruction redirects PC (Branch & Zero)
iBranchTarget  input  64  redirect address
oPC  output  64  PC of presented instruction
oInstr  output  32  presented instruction word
oOpcode  output  11  oInstr[31:21], feeds control iOPCODE
oValid  output  1  oInstr/oOpcode/oPC valid
oFault  output  1  sticky fault flag
oFaultCode  output  2  00 none, 01 bus timeout, 10 misaligned target
oRetired  output  CNT_W  retired-instruction count, wraps

Behaviour:
- One clock iCLK; reset iRST is synchronous and active-high.
- Reset values: state S_BOOT, oPC=RESET_PC&~3, oInstr=0, oValid=0, oFault=0, oFaultCode=00, oRetired=0, wait counter=0. oIMemReq=0 during reset.
- States: S_BOOT, S_REQ, S_HOLD, S_FAULT. oIMemReq = (state==S_REQ), decoded combinationally. oIMemAddr = oPC at all times.
- S_BOOT: go to S_REQ next cycle unconditionally.
- S_REQ:
  - oPC is held stable until ack.
  - iIMemAck=1: register oInstr<=iIMemData, oValid<=1, clear wait counter, go to S_HOLD.
  - No ack: increment wait counter. When the counter reaches TIMEOUT-1 and there is still no ack, go to S_FAULT with code 01.
  - Ack arriving on the limit cycle wins over the timeout.
- S_HOLD:
  - oValid=1 and outputs are stable.
  - iIMemAck is ignored.
  - iRetire=1: compute next = iBranchTaken ? iBranchTarget : oPC+4. The add is 64-bit modulo, so 64'hFFFF_FFFF_FFFF_FFFC wraps to 0. Increment oRetired modulo 2^CNT_W.
  - If next[1:0]!=0: oPC<=next (kept for debug), go to S_FAULT with code 10.
  - Otherwise oPC<=next, oValid<=0, go to S_REQ.
  - iBranchTaken and iBranchTarget are don't-care unless in S_HOLD with iRetire=1.
- S_FAULT: sticky until iRST. oValid=0, oIMemReq=0, all inputs ignored. oFault=1 while in S_FAULT; oFaultCode is held.
- oOpcode is continuously oInstr[31:21].
- Latency: retire at edge t puts the request in cycle t+1. Zero-wait ack in that cycle gives oValid=1 at t+2. Zero-wait throughput is one instruction per 2 cycles.
- Reset asserted mid-request or mid-hold: next edge returns to reset values. A late ack arriving after reset is ignored, because S_BOOT does not sample.

Decomposition:
- Shared parameter file (Parametros.v) holds:
  - fetch state encodings FS_BOOT/FS_REQ/FS_HOLD/FS_FAULT;
  - fault codes FLT_NONE/FLT_TIMEOUT/FLT_ALIGN;
  - OPC_MSB=31 and OPC_LSB=21;
  - INSTR_BYTES=4.
- One sub-module, legv8_next_pc: combinational next-PC mux, +4 adder and alignment check. Outputs are next address and misaligned flag.

Test Plan:
- Reset, then memory acks in the first S_REQ cycle with 32'h8B020020 (ADD) -> oIMemAddr=0; oValid=1 two cycles after reset release; oOpcode=11'h458; oPC=0.
- Ack delayed 3 cycles -> oIMemReq held high for 4 cycles with oIMemAddr constant; oValid rises the cycle after ack; oFault stays 0.
- Retire with iBranchTaken=0 at PC=0x10 -> next request addr 0x14; oRetired increments by 1. Retire with iBranchTaken=1, target 0x100 -> request addr 0x100.
- iBranchTaken=1, iBranchTarget=0x102 on retire -> S_FAULT, oFaultCode=10, oPC=0x102, oIMemReq stays 0 for 20 cycles despite iRetire pulses.
- No ack for TIMEOUT=16 cycles -> oFault=1 and code 01 after cycle 16. Separate run with ack exactly on the 16th cycle -> no fault, oValid=1.
- PC=64'hFFFF_FFFF_FFFF_FFFC, sequential retire -> next request addr 0. Reset pulsed while in S_REQ with ack pending -> reset values restored, ack ignored, fetch restarts at RESET_PC.
